// File: rtl/stream_sel_mux.sv
// stream_sel_mux: N-to-1 stream multiplexer with a one-beat output register.
// Channels are picked round-robin, starting the search at a rotating pointer.
// Define STREAM_SEL_MUX_LOCK_EN to build with packet locking. A channel that
// sends a beat with in_last=0 then keeps the grant until it sends in_last=1.
// Without the macro every beat is arbitrated on its own. in_last is still
// carried through to out_last.

module stream_sel_mux #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_chan
);

    // Output holding register and arbitration pointer
    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic                r_last;
    logic [SEL_W-1:0]    r_chan;
    logic [SEL_W-1:0]    r_ptr;

    // Arbitration and handshake wires
    logic                w_load_en;
    logic                w_xfer;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_rr_idx;
    logic [SEL_W:0]      w_sum;
    logic [CHANNELS-1:0] w_rot;
    logic [SEL_W-1:0]    w_grant;
    logic                w_cand_vld;
    logic                w_grant_vld;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [WIDTH-1:0]    w_sel_data;
    logic [SEL_W-1:0]    w_grant_inc;
    logic                w_ptr_upd;

`ifdef STREAM_SEL_MUX_LOCK_EN
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_lock_chan;
    logic [SEL_W-1:0] w_lock_nxt;
`endif

    // The register can take a new beat when it is empty or is being drained.
    assign w_load_en = !r_valid || out_ready;

    // Rotate in_valid so that bit 0 is the channel at ptr. The first set bit
    // is then the round-robin winner. Its offset is added back onto ptr,
    // modulo CHANNELS.
    always_comb begin
        w_rot    = CHANNELS'({in_valid, in_valid} >> r_ptr);
        w_rr_vld = 1'b0;
        w_sum    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!w_rr_vld && w_rot[k]) begin
                w_rr_vld = 1'b1;
                w_sum    = {1'b0, r_ptr} + (SEL_W+1)'(k);
            end
        end
        if (w_sum >= (SEL_W+1)'(CHANNELS))
            w_rr_idx = SEL_W'(w_sum - (SEL_W+1)'(CHANNELS));
        else
            w_rr_idx = SEL_W'(w_sum);
    end

    // Pick the candidate channel. A held lock overrides round-robin, even when
    // the locked channel is idle.
    always_comb begin
        w_grant    = w_rr_idx;
        w_cand_vld = w_rr_vld;
`ifdef STREAM_SEL_MUX_LOCK_EN
        if (r_state == LOCKED) begin
            w_grant    = r_lock_chan;
            w_cand_vld = 1'b1;
        end
`endif
    end

    // Select valid, last and data of the candidate channel.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_sel_valid = in_valid[k];
                w_sel_last  = in_last[k];
                w_sel_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A grant needs a valid beat on the candidate channel.
    assign w_grant_vld = w_cand_vld && w_sel_valid;

    // A transfer needs a grant and room in the output register.
    // Reset blocks all transfers.
    assign w_xfer      = rst_n && w_grant_vld && w_load_en;

    // Only the granted channel sees ready. It is the same as the transfer strobe.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < CHANNELS; k++)
            in_ready[k] = w_xfer && (w_grant == SEL_W'(k));
    end

    // The channel after the grant, wrapping to 0 past the top channel.
    assign w_grant_inc = (w_grant == SEL_W'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;

`ifdef STREAM_SEL_MUX_LOCK_EN
    // Next state: a non-last beat while unlocked takes the lock; a last beat
    // releases it.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_chan;
        if (w_xfer) begin
            case (r_state)
                UNLOCKED: begin
                    if (!w_sel_last) begin
                        w_state_nxt = LOCKED;
                        w_lock_nxt  = w_grant;
                    end
                end
                LOCKED: begin
                    if (w_sel_last)
                        w_state_nxt = UNLOCKED;
                end
                default: w_state_nxt = UNLOCKED;
            endcase
        end
    end

    // Lock state register. Reset drops any partial packet lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= UNLOCKED;
            r_lock_chan <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_chan <= w_lock_nxt;
        end
    end

    // The pointer moves only when a transfer leaves the mux unlocked.
    // While locked, w_grant is the lock channel, so this covers the release.
    assign w_ptr_upd = w_xfer && (w_state_nxt == UNLOCKED);
`else
    assign w_ptr_upd = w_xfer;
`endif

    // Round-robin pointer: the search restarts just after the last winner.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_ptr_upd)
            r_ptr <= w_grant_inc;
    end

    // Output register: load on transfer, empty on drain without refill.
    // Hold the contents otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_chan  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_last  <= w_sel_last;
            r_chan  <= w_grant;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_chan  = r_chan;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Bench for stream_sel_mux with WIDTH=32 and CHANNELS=4. Each channel is fed
// from a beat buffer. A cycle-level reference model, built from the
// arbitration rules, predicts in_ready and the registered outputs on every
// cycle. Directed scenarios also check fixed expected values.

module tb_stream_sel_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
`ifdef STREAM_SEL_MUX_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_last = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [SW-1:0]   out_chan;

    stream_sel_mux #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_chan(out_chan)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Per-channel source buffers
    logic [W-1:0] bd [N][64];
    bit           bl [N][64];
    int           hd [N];
    int           tl [N];
    bit           en [N];

    // Reference model state
    int           m_ptr = 0;
    bit           m_lk = 1'b0;
    int           m_lc = 0;
    bit           m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    bit           m_ol = 1'b0;
    int           m_oc = 0;

    task automatic clear_q();
        for (int c = 0; c < N; c++) begin
            hd[c] = 0;
            tl[c] = 0;
            en[c] = 1'b1;
        end
    endtask

    task automatic push(input int c, input logic [W-1:0] d, input bit l);
        if (tl[c] < 63) begin
            bd[c][tl[c]] = d;
            bl[c][tl[c]] = l;
            tl[c]++;
        end
    endtask

    // Run one clock. Check in_ready before the edge and the outputs after it.
    task automatic step(input string name);
        int g;
        bit ld;
        logic [N-1:0] er;
        for (int c = 0; c < N; c++) begin
            in_valid[c]        = en[c] && (hd[c] < tl[c]);
            in_data[c*W +: W]  = (hd[c] < tl[c]) ? bd[c][hd[c]] : '0;
            in_last[c]         = (hd[c] < tl[c]) ? bl[c][hd[c]] : 1'b0;
        end
        #1;
        g = -1;
        if (rst_n) begin
            if (m_lk) begin
                if (in_valid[m_lc]) g = m_lc;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        ld = !m_ov || out_ready;
        er = '0;
        if (g >= 0 && ld) er[g] = 1'b1;
        n_chk++;
        if (in_ready !== er) begin
            n_fail++;
            $display("FAIL %s in_ready got %b want %b", name, in_ready, er);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_oc = 0; m_ptr = 0; m_lk = 1'b0;
        end else if (g >= 0 && ld) begin
            m_ov = 1'b1;
            m_od = bd[g][hd[g]];
            m_ol = bl[g][hd[g]];
            m_oc = g;
            hd[g]++;
            if (!m_lk) begin
                if (LOCK && !m_ol) begin
                    m_lk = 1'b1;
                    m_lc = g;
                end else begin
                    m_ptr = (g + 1) % N;
                end
            end else if (m_ol) begin
                m_lk  = 1'b0;
                m_ptr = (m_lc + 1) % N;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        n_chk++;
        if (out_valid !== m_ov) begin
            n_fail++;
            $display("FAIL %s out_valid got %b want %b", name, out_valid, m_ov);
        end
        n_chk++;
        if (out_data !== m_od || out_last !== m_ol || out_chan !== SW'(m_oc)) begin
            n_fail++;
            $display("FAIL %s out data/last/chan got %h/%b/%0d want %h/%b/%0d",
                     name, out_data, out_last, out_chan, m_od, m_ol, m_oc);
        end
    endtask

    task automatic do_reset();
        clear_q();
        out_ready = 1'b0;
        rst_n = 1'b0;
        step("reset");
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        bit busy;
        n = 0;
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) en[c] = 1'b1;
        busy = 1'b1;
        while (busy && n < 200) begin
            step("drain");
            n++;
            busy = m_ov;
            for (int c = 0; c < N; c++) if (hd[c] < tl[c]) busy = 1'b1;
        end
        n_chk++;
        if (busy) begin
            n_fail++;
            $display("FAIL drain timeout got %0d cycles want < 200", n);
        end
    endtask

    task automatic test_reset();
        clear_q();
        for (int c = 0; c < N; c++) push(c, 32'h5000 + 32'(c), 1'b1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        step("rst_a");
        step("rst_b");
        n_chk++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== 32'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got v%b c%0d d%h l%b want 0", out_valid, out_chan, out_data, out_last);
        end
        n_chk++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 0000", in_ready);
        end
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_round_robin();
        int exp_c [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int c = 0; c < N; c++) begin
            push(c, 32'hA0 + 32'(c), 1'b1);
            push(c, 32'hA0 + 32'(c), 1'b1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("rr");
            n_chk++;
            if (out_valid !== 1'b1 || out_chan !== SW'(exp_c[i]) || out_data !== 32'hA0 + 32'(exp_c[i])) begin
                n_fail++;
                $display("FAIL rr_seq[%0d] got v%b c%0d d%h want v1 c%0d d%h", i, out_valid,
                         out_chan, out_data, exp_c[i], 32'hA0 + 32'(exp_c[i]));
            end
        end
        drain();
    endtask

    task automatic test_hold();
        do_reset();
        push(2, 32'hDEADBEEF, 1'b1);
        out_ready = 1'b0;
        step("hold_load");
        push(0, 32'h0C0FFEE0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("hold");
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_chan !== 2'd2 || in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold[%0d] got v%b d%h c%0d r%b want v1 dDEADBEEF c2 r0000",
                         i, out_valid, out_data, out_chan, in_ready);
            end
        end
        out_ready = 1'b1;
        step("hold_release");
        n_chk++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'h0C0FFEE0) begin
            n_fail++;
            $display("FAIL hold_release got v%b c%0d d%h want v1 c0 d0C0FFEE0", out_valid, out_chan, out_data);
        end
        drain();
    endtask

    task automatic test_lock();
        int exp_c [7];
        if (LOCK) exp_c = '{0, 1, 1, 1, 3, 0, 3};
        else      exp_c = '{0, 1, 3, 0, 1, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h100 + 32'(i), 1'b1);
            push(3, 32'h300 + 32'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) push(1, 32'h110 + 32'(i), i == 2);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step("lock");
            n_chk++;
            if (out_valid !== 1'b1 || out_chan !== SW'(exp_c[i])) begin
                n_fail++;
                $display("FAIL lock_seq[%0d] got v%b c%0d want v1 c%0d", i, out_valid, out_chan, exp_c[i]);
            end
        end
        drain();
    endtask

    task automatic test_reset_locked();
        do_reset();
        push(1, 32'h55, 1'b0);
        out_ready = 1'b0;
        step("rl_load");
        push(0, 32'h66, 1'b1);
        push(1, 32'h57, 1'b1);
        rst_n = 1'b0;
        step("rl_reset");
        rst_n = 1'b1;
        n_chk++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0) begin
            n_fail++;
            $display("FAIL rl_reset got v%b c%0d want v0 c0", out_valid, out_chan);
        end
        out_ready = 1'b1;
        step("rl_restart");
        n_chk++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'h66) begin
            n_fail++;
            $display("FAIL rl_restart got v%b c%0d d%h want v1 c0 d66", out_valid, out_chan, out_data);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        push(3, 32'h33, 1'b1);
        out_ready = 1'b1;
        step("wrap");
        n_chk++;
        if (out_valid !== 1'b1 || out_chan !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap got v%b c%0d want v1 c3", out_valid, out_chan);
        end
        push(0, 32'h44, 1'b1);
        push(2, 32'h22, 1'b1);
        step("wrap_next");
        n_chk++;
        if (out_chan !== 2'd0 || out_data !== 32'h44) begin
            n_fail++;
            $display("FAIL wrap_next got c%0d d%h want c0 d44", out_chan, out_data);
        end
        drain();
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N; c++) begin
                n = int'($urandom_range(1, 20));
                for (int i = 0; i < n; i++)
                    push(c, $urandom, (i == n - 1) ? 1'b1 : ($urandom_range(0, 2) == 0));
            end
            for (int t = 0; t < 150; t++) begin
                for (int c = 0; c < N; c++) en[c] = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                step("rand");
            end
        end
        drain();
    endtask

    initial begin
        clear_q();
        test_reset();
        test_round_robin();
        test_hold();
        test_lock();
        test_reset_locked();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_sel_mux.md
STREAM_SEL_MUX -- requirements
Module: stream_sel_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels, legal range 1..32.
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(CHANNELS)), channel-index width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  CHANNELS  per-channel beat valid.
REQ-007 SHALL have port in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  CHANNELS  per-channel end-of-packet flag.
REQ-009 SHALL have port in_ready  output  CHANNELS  per-channel accept, combinational.
REQ-010 SHALL have port out_valid  output  1  registered output beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-013 SHALL have port out_last  output  1  registered last flag of the held beat.
REQ-014 SHALL have port out_chan  output  SEL_W  index of the source channel of the held beat.

Function
REQ-015 SHALL hold one beat in an output register; load_en = !out_valid | out_ready.
REQ-016 SHALL grant one channel g per cycle, the first channel with in_valid set, searching ptr, ptr+1, ... wrapping CHANNELS-1 to 0; no valid channel means no grant.
REQ-017 SHALL assert in_ready[g] = load_en only for the granted channel; all other in_ready bits 0.
REQ-018 SHALL transfer from channel g when in_valid[g] & in_ready[g]; out_data, out_last, out_chan load next edge (latency 1 cycle), out_valid <= 1.
REQ-019 SHALL set out_valid <= 0 when out_valid & out_ready and no transfer occurs the same cycle.
REQ-020 SHALL hold out_data/out_last/out_chan stable while out_valid & !out_ready.
REQ-021 SHALL sustain one beat per cycle when out_ready is held high (simultaneous drain and load).
REQ-022 SHALL update ptr <= (g+1) mod CHANNELS on each transfer that leaves the FSM in UNLOCKED; ptr unchanged otherwise.
REQ-023 SHALL, with CHANNELS=1, pass channel 0 through with out_chan = 0.

Reset
REQ-024 SHALL, on rising edge with rst_n=0, set out_valid=0, out_data=0, out_last=0, out_chan=0, ptr=0, FSM=UNLOCKED.
REQ-025 SHALL drive in_ready=0 on all channels while rst_n=0.
REQ-026 SHALL discard any held beat and any partial packet lock on reset mid-operation; no beat is replayed.

Configuration
REQ-027 SHALL compile packet locking only when macro STREAM_SEL_MUX_LOCK_EN is defined.
REQ-028 SHALL, with STREAM_SEL_MUX_LOCK_EN, run FSM UNLOCKED/LOCKED: transfer with in_last=0 from g in UNLOCKED -> LOCKED, lock_chan <= g.
REQ-029 SHALL, in LOCKED, grant only lock_chan regardless of other in_valid (in_ready of others 0, even if lock_chan idle); transfer with in_last=1 -> UNLOCKED, ptr <= lock_chan+1 mod CHANNELS.
REQ-030 SHALL, without STREAM_SEL_MUX_LOCK_EN, arbitrate every beat independently, ignore in_last for grant, still register it to out_last; no FSM state.

Verification (WIDTH=32, CHANNELS=4)
REQ-031 SHALL cover: reset, then in_valid=4'b1111, data 0xA0..0xA3, out_ready=1 -> out_chan 0,1,2,3,0 on consecutive cycles, out_valid high from cycle 2.
REQ-032 SHALL cover: single beat ch2 0xDEADBEEF, out_ready=0 for 3 cycles -> out_data held 0xDEADBEEF, out_chan=2, in_ready=0 all channels until out_ready=1.
REQ-033 SHALL cover (LOCK_EN): ch1 3-beat packet (last on beat 3), ch0/ch3 valid throughout -> three ch1 beats contiguous, next grant ch3 (ptr=2 search).
REQ-034 SHALL cover (no LOCK_EN): same stimulus as REQ-033 -> beats interleave ch0,ch1,ch3,ch0,...
REQ-035 SHALL cover: rst_n low one cycle while LOCKED with out_valid=1 -> next cycle out_valid=0, out_chan=0, grant restarts at ch0.
REQ-036 SHALL cover: only ch3 valid, ptr=0 -> wrap-around grant ch3, then ptr=0.
